fwd_scoreboard_unit: RTL and testbench
======================================

// Module: fwd_scoreboard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the pipelined RV32 core. Per EX-stage
//  source it selects the youngest in-flight producer among NUM_FWD stages, or the register file.
//  A per-register latency scoreboard stalls ID until a multi-cycle result (load, mul) is
//  forwardable. Also counts stall cycles for perf reporting.
// PARAMETERS
//  NUM_SRC   2  source operands per instruction (rs1, rs2[, rs3])
//  NUM_FWD   2  forwarding stages after EX; index 0 = youngest (MEM), 1 = WB, ...
//  MAX_LAT   3  largest producer latency in cycles; larger ID_Lat_i values clamp to it
//  CNT_W     2  scoreboard counter width, = $clog2(MAX_LAT+1)
//  SEL_W     2  forward-select width, = $clog2(NUM_FWD+1)
// PORTS
//  clk_i         in   1            clock, all state on rising edge
//  rst_i         in   1            synchronous reset, active-high
//  ID_Valid_i    in   1            ID holds a real instruction
//  ID_Rs_i       in   NUM_SRC*5    ID source regs, src k at [5k+:5]
//  ID_RsUsed_i   in   NUM_SRC      src k actually read
//  ID_RegWrite_i in   1            ID instr writes rd
//  ID_Rd_i       in   5            ID destination
//  ID_Lat_i      in   CNT_W        cycles after issue until result forwardable (0 = ALU)
//  Flush_i       in   1            kill the ID instruction this cycle
//  EX_Rs_i       in   NUM_SRC*5    EX source regs
//  FWD_RegWrite_i in  NUM_FWD      stage s writes rd
//  FWD_Rd_i      in   NUM_FWD*5    stage s rd at [5s+:5]
//  Stall_o       out  1            hold PC and IF/ID, bubble ID/EX
//  Fwd_Sel_o     out  NUM_SRC*SEL_W  per src: 0 = regfile, s+1 = stage s
//  Stall_Cnt_o   out  32           total stall cycles since reset
// BEHAVIOUR
//  - Reset: all 31 counters = 0, Stall_Cnt_o = 0; Stall_o forced 0 while rst_i = 1.
//  - Forward (combinational): Fwd_Sel_o[k] = s+1 for the LOWEST s with FWD_RegWrite_i[s] and
//    FWD_Rd_i[s] == EX_Rs[k] != 0; otherwise 0. x0 never forwarded. Sources independent.
//  - Scoreboard: cnt[r], r = 1..31 (x0 has no entry, always ready).
//  - Stall_o = ID_Valid_i & !Flush_i & OR over k of (ID_RsUsed_i[k] & ID_Rs[k] != 0 &
//    cnt[ID_Rs[k]] != 0). Combinational from current cnt, no extra latency.
//  - issue = ID_Valid_i & !Stall_o & !Flush_i & ID_RegWrite_i & ID_Rd_i != 0.
//  - Each edge: on issue, cnt[ID_Rd_i] <= min(ID_Lat_i, MAX_LAT); this set wins over decrement
//    of the same entry. Every other nonzero cnt decrements by 1; zero stays zero.
//  - Result: producer issued at edge t with latency L -> dependent ID instr stalls exactly L
//    cycles, issues at edge t+L+1, then reaches EX when producer sits in a forward stage.
//  - Rd == own Rs (e.g. lw x5,0(x5)): own stall uses old cnt; set applies after issue.
//  - Flush_i: ID instr writes nothing, causes no stall; in-flight counters keep counting.
//  - Stall_Cnt_o += 1 on each cycle with Stall_o = 1; saturates at 32'hFFFF_FFFF.
//  - Reset mid-stall: next cycle all counters 0, Stall_o = 0, counter 0.
// STRUCTURE
//  - Shared pkg (core_pkg): REG_ADDR_W = 5, FWD_SEL_RF = 0, stage-index constants.
//  - Sub-module fwd_select: one instance per source, combinational NUM_FWD priority mux-select.
//  - Scoreboard array, stall logic and perf counter live in top.
// TESTING
//  1 ALU chain: add x1; next add x3,x1,x2 in EX with MEM rd=x1 -> Fwd_Sel rs1=1, Stall_o=0.
//  2 Priority: MEM and WB both rd=x4, EX rs2=x4 -> sel=1; MEM rd=x0 only -> sel=0.
//  3 Load-use: lw x5 issued with Lat=1; next ID reads x5 -> Stall_o=1 for 1 cycle, Stall_Cnt=1.
//  4 Lat=3 (mul) to x7, dependent in ID -> 3 stall cycles; Lat=5 clamps to 3 stalls.
//  5 Flush_i with lw x6 in ID -> cnt[x6] stays 0; following reader of x6 no stall.
//  6 rst_i during 2nd stall cycle -> next cycle Stall_o=0, Stall_Cnt_o=0, all reads ready.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline constants for the forwarding/scoreboard slice of the RV32 core.
// Forward-select encoding: 0 = register file, s+1 = forwarding stage s.
package core_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FWD_SEL_RF = 0;
    localparam int STAGE_MEM  = 0;
    localparam int STAGE_WB   = 1;

    function automatic int fwd_sel_of(input int stage);
        return stage + 1;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_unit_fwd_select.sv
// Priority forward select for one EX source: youngest writing stage whose rd matches wins.
// x0 is never forwarded.
module fwd_select
    import core_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int SEL_W   = 2
) (
    input  logic [REG_ADDR_W-1:0]         rs,
    input  logic [NUM_FWD-1:0]            fwd_we,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
    output logic [SEL_W-1:0]              sel
);

    // Walk oldest to youngest so the lowest matching stage index is the last write.
    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        for (int s = NUM_FWD - 1; s >= 0; s--) begin
            if (fwd_we[s] && (rs != '0) && (fwd_rd[s*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
                sel = SEL_W'(fwd_sel_of(s));
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding select plus per-register latency scoreboard that stalls ID until a
// multi-cycle producer is forwardable; also counts stall cycles for perf reporting.
module fwd_scoreboard_unit
    import core_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int MAX_LAT = 3,
    parameter int CNT_W   = $clog2(MAX_LAT + 1),
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ID_Valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_Rs_i,
    input  logic [NUM_SRC-1:0]            ID_RsUsed_i,
    input  logic                          ID_RegWrite_i,
    input  logic [REG_ADDR_W-1:0]         ID_Rd_i,
    input  logic [CNT_W-1:0]              ID_Lat_i,
    input  logic                          Flush_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] EX_Rs_i,
    input  logic [NUM_FWD-1:0]            FWD_RegWrite_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] FWD_Rd_i,
    output logic                          Stall_o,
    output logic [NUM_SRC*SEL_W-1:0]      Fwd_Sel_o,
    output logic [31:0]                   Stall_Cnt_o
);

    // Entry 0 exists only so register addresses index directly; it is never set.
    logic [CNT_W-1:0] cnt [32];
    logic [CNT_W-1:0] lat_clamp;
    logic             stall;
    logic             issue;
    logic [31:0]      stall_cnt;

    genvar k;
    generate
        for (k = 0; k < NUM_SRC; k++) begin : g_src
            fwd_select #(
                .NUM_FWD (NUM_FWD),
                .SEL_W   (SEL_W)
            ) u_fwd_select (
                .rs     (EX_Rs_i[k*REG_ADDR_W +: REG_ADDR_W]),
                .fwd_we (FWD_RegWrite_i),
                .fwd_rd (FWD_Rd_i),
                .sel    (Fwd_Sel_o[k*SEL_W +: SEL_W])
            );
        end
    endgenerate

    always_comb begin
        stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (ID_RsUsed_i[s] && (ID_Rs_i[s*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                (cnt[ID_Rs_i[s*REG_ADDR_W +: REG_ADDR_W]] != '0)) begin
                stall = 1'b1;
            end
        end
        stall = stall & ID_Valid_i & ~Flush_i & ~rst_i;
    end

    always_comb begin
        lat_clamp = ID_Lat_i;
        if (ID_Lat_i > CNT_W'(MAX_LAT)) begin
            lat_clamp = CNT_W'(MAX_LAT);
        end
    end

    assign issue = ID_Valid_i & ~stall & ~Flush_i & ID_RegWrite_i & (ID_Rd_i != '0);

    // A fresh issue overrides the decrement of the same entry, so Rd == Rs reloads cleanly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (issue && (ID_Rd_i == REG_ADDR_W'(r))) begin
                    cnt[r] <= lat_clamp;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign Stall_o     = stall;
    assign Stall_Cnt_o = stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: default instance plus a wide-latency
// instance (CNT_W=3) so latencies above MAX_LAT can be driven to exercise clamping.
module tb_fwd_scoreboard_unit;

    typedef struct {
        logic        v;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [1:0]  used;
        logic        rw;
        logic [4:0]  rd;
        logic [2:0]  lat;
        logic        fl;
        logic        rst;
        logic        s;
        logic        sw;
    } step_t;

    typedef struct {
        logic [4:0]  ex1;
        logic [4:0]  ex2;
        logic [1:0]  we;
        logic [4:0]  rd_mem;
        logic [4:0]  rd_wb;
        logic [1:0]  s0;
        logic [1:0]  s1;
    } fstep_t;

    typedef struct {
        logic        stall;
        logic        stall_w;
        logic [3:0]  sel;
        logic [31:0] scnt;
        logic [31:0] scnt_w;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_used;
    logic        id_rw;
    logic [4:0]  id_rd;
    logic [2:0]  lat_w;
    logic        flush;
    logic [9:0]  ex_rs;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_rd;
    logic        stall;
    logic        stall_w;
    logic [3:0]  sel;
    logic [3:0]  sel_w;
    logic [31:0] scnt;
    logic [31:0] scnt_w;

    exp_t        sb[$];
    int          errors;
    int          checks;
    logic [31:0] exp_scnt;
    logic [31:0] exp_scnt_w;

    fwd_scoreboard_unit dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ID_Valid_i     (id_valid),
        .ID_Rs_i        (id_rs),
        .ID_RsUsed_i    (id_used),
        .ID_RegWrite_i  (id_rw),
        .ID_Rd_i        (id_rd),
        .ID_Lat_i       (lat_w[1:0]),
        .Flush_i        (flush),
        .EX_Rs_i        (ex_rs),
        .FWD_RegWrite_i (fwd_we),
        .FWD_Rd_i       (fwd_rd),
        .Stall_o        (stall),
        .Fwd_Sel_o      (sel),
        .Stall_Cnt_o    (scnt)
    );

    fwd_scoreboard_unit #(
        .MAX_LAT (3),
        .CNT_W   (3)
    ) dut_w (
        .clk_i          (clk),
        .rst_i          (rst),
        .ID_Valid_i     (id_valid),
        .ID_Rs_i        (id_rs),
        .ID_RsUsed_i    (id_used),
        .ID_RegWrite_i  (id_rw),
        .ID_Rd_i        (id_rd),
        .ID_Lat_i       (lat_w),
        .Flush_i        (flush),
        .EX_Rs_i        (ex_rs),
        .FWD_RegWrite_i (fwd_we),
        .FWD_Rd_i       (fwd_rd),
        .Stall_o        (stall_w),
        .Fwd_Sel_o      (sel_w),
        .Stall_Cnt_o    (scnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input step_t t);
        id_valid = t.v;
        id_rs    = {t.r2, t.r1};
        id_used  = t.used;
        id_rw    = t.rw;
        id_rd    = t.rd;
        lat_w    = t.lat;
        flush    = t.fl;
        rst      = t.rst;
    endtask

    task automatic test_reset();
        step_t t[$];
        exp_t  e;
        t.push_back('{1'b1, 5'd1, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd31, 5'd1, 2'b11, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd17, 5'd2, 2'b11, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        foreach (t[i]) begin
            @(negedge clk);
            drive(t[i]);
            sb.push_back('{t[i].s, t[i].sw, 4'd0, exp_scnt, exp_scnt_w});
            #1;
            e = sb.pop_front();
            if (stall !== e.stall) begin
                $display("FAIL reset_stall step %0d: got %b want %b", i, stall, e.stall);
                errors++;
            end
            checks++;
            if (scnt !== e.scnt) begin
                $display("FAIL reset_stall_cnt step %0d: got %0d want %0d", i, scnt, e.scnt);
                errors++;
            end
            checks++;
            if (sel !== e.sel) begin
                $display("FAIL reset_sel step %0d: got %h want %h", i, sel, e.sel);
                errors++;
            end
            checks++;
            if (t[i].rst) begin
                exp_scnt = 0;
                exp_scnt_w = 0;
            end else begin
                exp_scnt += 32'(e.stall);
                exp_scnt_w += 32'(e.stall_w);
            end
        end
    endtask

    task automatic test_alu_chain();
        exp_t e;
        @(negedge clk);
        drive('{1'b1, 5'd2, 5'd0, 2'b01, 1'b1, 5'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        ex_rs = '0; fwd_we = '0; fwd_rd = '0;
        sb.push_back('{1'b0, 1'b0, 4'd0, exp_scnt, exp_scnt_w});
        #1;
        e = sb.pop_front();
        if (stall !== e.stall) begin
            $display("FAIL alu_issue_stall: got %b want %b", stall, e.stall);
            errors++;
        end
        checks++;
        @(negedge clk);
        drive('{1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        ex_rs = {5'd2, 5'd1}; fwd_we = 2'b01; fwd_rd = {5'd0, 5'd1};
        sb.push_back('{1'b0, 1'b0, {2'd0, 2'd1}, exp_scnt, exp_scnt_w});
        #1;
        e = sb.pop_front();
        if (stall !== e.stall) begin
            $display("FAIL alu_dep_stall: got %b want %b", stall, e.stall);
            errors++;
        end
        checks++;
        if (sel !== e.sel) begin
            $display("FAIL alu_dep_sel: got %h want %h", sel, e.sel);
            errors++;
        end
        checks++;
        @(negedge clk);
        id_valid = 1'b0; ex_rs = '0; fwd_we = '0; fwd_rd = '0;
    endtask

    task automatic test_priority();
        fstep_t f[$];
        exp_t   e;
        f.push_back('{5'd0, 5'd4, 2'b11, 5'd4, 5'd4, 2'd0, 2'd1});
        f.push_back('{5'd4, 5'd4, 2'b10, 5'd4, 5'd4, 2'd2, 2'd2});
        f.push_back('{5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 2'd0, 2'd0});
        f.push_back('{5'd4, 5'd9, 2'b11, 5'd0, 5'd4, 2'd2, 2'd0});
        f.push_back('{5'd7, 5'd4, 2'b01, 5'd7, 5'd4, 2'd1, 2'd0});
        f.push_back('{5'd3, 5'd3, 2'b11, 5'd3, 5'd5, 2'd1, 2'd1});
        foreach (f[i]) begin
            @(negedge clk);
            id_valid = 1'b0;
            ex_rs  = {f[i].ex2, f[i].ex1};
            fwd_we = f[i].we;
            fwd_rd = {f[i].rd_wb, f[i].rd_mem};
            sb.push_back('{1'b0, 1'b0, {f[i].s1, f[i].s0}, exp_scnt, exp_scnt_w});
            #1;
            e = sb.pop_front();
            if (sel !== e.sel) begin
                $display("FAIL priority_sel step %0d: got %h want %h", i, sel, e.sel);
                errors++;
            end
            checks++;
            if (sel_w !== e.sel) begin
                $display("FAIL priority_sel_w step %0d: got %h want %h", i, sel_w, e.sel);
                errors++;
            end
            checks++;
        end
        @(negedge clk);
        ex_rs = '0; fwd_we = '0; fwd_rd = '0;
    endtask

    // Shared per-step checker body is written out in each scenario task below.
    task automatic test_load_use();
        step_t t[$];
        exp_t  e;
        t.push_back('{1'b1, 5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1});
        t.push_back('{1'b1, 5'd5, 5'd0, 2'b01, 1'b1, 5'd5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        t.push_back('{1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        foreach (t[i]) begin
            @(negedge clk);
            drive(t[i]);
            sb.push_back('{t[i].s, t[i].sw, 4'd0, exp_scnt, exp_scnt_w});
            #1;
            e = sb.pop_front();
            if (stall !== e.stall) begin
                $display("FAIL load_use_stall step %0d: got %b want %b", i, stall, e.stall);
                errors++;
            end
            checks++;
            if (scnt !== e.scnt) begin
                $display("FAIL load_use_cnt step %0d: got %0d want %0d", i, scnt, e.scnt);
                errors++;
            end
            checks++;
            exp_scnt += 32'(e.stall);
            exp_scnt_w += 32'(e.stall_w);
        end
    endtask

    task automatic test_mul_clamp();
        step_t t[$];
        exp_t  e;
        t.push_back('{1'b1, 5'd1, 5'd0, 2'b01, 1'b1, 5'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd7, 5'd2, 2'b11, 1'b1, 5'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        t.push_back('{1'b1, 5'd7, 5'd2, 2'b11, 1'b1, 5'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        t.push_back('{1'b1, 5'd7, 5'd2, 2'b11, 1'b1, 5'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        t.push_back('{1'b1, 5'd7, 5'd2, 2'b11, 1'b1, 5'd8, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd0, 5'd9, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        t.push_back('{1'b1, 5'd0, 5'd9, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        t.push_back('{1'b1, 5'd0, 5'd9, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        t.push_back('{1'b1, 5'd0, 5'd9, 2'b10, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        foreach (t[i]) begin
            @(negedge clk);
            drive(t[i]);
            sb.push_back('{t[i].s, t[i].sw, 4'd0, exp_scnt, exp_scnt_w});
            #1;
            e = sb.pop_front();
            if (stall !== e.stall) begin
                $display("FAIL mul_stall step %0d: got %b want %b", i, stall, e.stall);
                errors++;
            end
            checks++;
            if (stall_w !== e.stall_w) begin
                $display("FAIL clamp_stall_w step %0d: got %b want %b", i, stall_w, e.stall_w);
                errors++;
            end
            checks++;
            if (scnt !== e.scnt) begin
                $display("FAIL mul_cnt step %0d: got %0d want %0d", i, scnt, e.scnt);
                errors++;
            end
            checks++;
            if (scnt_w !== e.scnt_w) begin
                $display("FAIL clamp_cnt_w step %0d: got %0d want %0d", i, scnt_w, e.scnt_w);
                errors++;
            end
            checks++;
            exp_scnt += 32'(e.stall);
            exp_scnt_w += 32'(e.stall_w);
        end
    endtask

    task automatic test_flush();
        step_t t[$];
        exp_t  e;
        t.push_back('{1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd9, 5'd0, 2'b01, 1'b1, 5'd6, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd6, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        t.push_back('{1'b1, 5'd9, 5'd6, 2'b11, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        foreach (t[i]) begin
            @(negedge clk);
            drive(t[i]);
            sb.push_back('{t[i].s, t[i].sw, 4'd0, exp_scnt, exp_scnt_w});
            #1;
            e = sb.pop_front();
            if (stall !== e.stall) begin
                $display("FAIL flush_stall step %0d: got %b want %b", i, stall, e.stall);
                errors++;
            end
            checks++;
            if (scnt !== e.scnt) begin
                $display("FAIL flush_cnt step %0d: got %0d want %0d", i, scnt, e.scnt);
                errors++;
            end
            checks++;
            exp_scnt += 32'(e.stall);
            exp_scnt_w += 32'(e.stall_w);
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t t[$];
        exp_t  e;
        t.push_back('{1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
        t.push_back('{1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        t.push_back('{1'b1, 5'd7, 5'd9, 2'b11, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        foreach (t[i]) begin
            @(negedge clk);
            drive(t[i]);
            sb.push_back('{t[i].s, t[i].sw, 4'd0, exp_scnt, exp_scnt_w});
            #1;
            e = sb.pop_front();
            if (stall !== e.stall) begin
                $display("FAIL rst_mid_stall step %0d: got %b want %b", i, stall, e.stall);
                errors++;
            end
            checks++;
            if (scnt !== e.scnt) begin
                $display("FAIL rst_mid_cnt step %0d: got %0d want %0d", i, scnt, e.scnt);
                errors++;
            end
            checks++;
            if (t[i].rst) begin
                exp_scnt = 0;
                exp_scnt_w = 0;
            end else begin
                exp_scnt += 32'(e.stall);
                exp_scnt_w += 32'(e.stall_w);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_scnt = 0;
        exp_scnt_w = 0;
        rst = 1'b1;
        id_valid = 1'b0; id_rs = '0; id_used = '0; id_rw = 1'b0; id_rd = '0;
        lat_w = '0; flush = 1'b0; ex_rs = '0; fwd_we = '0; fwd_rd = '0;
        test_reset();
        test_alu_chain();
        test_priority();
        test_load_use();
        test_mul_clamp();
        test_flush();
        test_reset_mid_stall();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
            errors++;
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
